// File: rtl/cv32e40x_prefetcher_ot.sv
// cv32e40x_prefetcher_ot: issues branch/sequential fetch requests, limits how many are
// outstanding, and tags responses that belong to transactions issued before a taken branch.
module cv32e40x_prefetcher_ot #(
  parameter int ADDR_W          = 32,
  parameter int FETCH_BYTES     = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_branch_i,
  input  logic [ADDR_W-1:0] fetch_branch_addr_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic              fetch_ptr_access_i,
  output logic              fetch_ptr_access_o,
  input  logic [1:0]        fetch_priv_lvl_access_i,
  output logic [1:0]        fetch_priv_lvl_access_o,
  output logic              trans_valid_o,
  input  logic              trans_ready_i,
  output logic [ADDR_W-1:0] trans_addr_o,
  input  logic              resp_valid_i,
  output logic              resp_valid_o,
  output logic              resp_discard_o,
  output logic [CNT_W-1:0]  outstanding_o
);
  typedef enum logic {IDLE, BRANCH_WAIT} state_t;
  localparam logic [1:0]       PRIV_LVL_M = 2'b11;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, incr;
  logic              ptr_q, ptr_d;
  logic [1:0]        priv_q, priv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, discard_q, discard_d;
  logic              accept, wait_st, resp_dec;
  always_comb begin
    wait_st                 = state_q == BRANCH_WAIT;
    incr                    = {addr_q[ADDR_W-1:1], 1'b0} + ADDR_W'(FETCH_BYTES);
    trans_valid_o           = fetch_valid_i && (cnt_q < MAX_CNT);
    accept                  = trans_valid_o && trans_ready_i;
    fetch_ready_o           = accept;
    trans_addr_o            = fetch_branch_i ? fetch_branch_addr_i : wait_st ? addr_q : incr;
    fetch_ptr_access_o      = fetch_branch_i ? fetch_ptr_access_i : wait_st && ptr_q;
    fetch_priv_lvl_access_o = (wait_st && !fetch_branch_i) ? priv_q : fetch_priv_lvl_access_i;
    addr_d                  = (fetch_branch_i || accept) ? trans_addr_o : addr_q;
    ptr_d                   = (fetch_branch_i || accept) ? fetch_ptr_access_o : ptr_q;
    priv_d                  = (fetch_branch_i || accept) ? fetch_priv_lvl_access_o : priv_q;
    state_d                 = accept ? IDLE : fetch_branch_i ? BRANCH_WAIT : state_q;
    // A response with nothing outstanding is ignored so the count never underflows.
    resp_dec                = resp_valid_i && (cnt_q != '0);
    cnt_d                   = cnt_q + CNT_W'(accept) - CNT_W'(resp_dec);
    resp_valid_o            = resp_valid_i && (discard_q == '0);
    resp_discard_o          = resp_valid_i && (discard_q != '0);
    discard_d               = fetch_branch_i ? cnt_q - CNT_W'(resp_dec) :
                              resp_discard_o ? discard_q - 1'b1 : discard_q;
    outstanding_o           = cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ptr_q     <= 1'b0;
      priv_q    <= PRIV_LVL_M;
      cnt_q     <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      priv_q    <= priv_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end
  a_resp_with_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid_i |-> cnt_q != '0);
  a_discard_le_cnt: assert property (@(posedge clk) disable iff (!rst_n) discard_q <= cnt_q);
endmodule

// File: tb/tb_cv32e40x_prefetcher_ot.sv
// tb_cv32e40x_prefetcher_ot: vector table plus directed sequences for the prefetch controller.
module tb_cv32e40x_prefetcher_ot;
  logic        clk = 0, rst_n = 0;
  logic        br = 0, valid = 0, ptr_i = 0, ready = 0, resp = 0;
  logic [31:0] baddr = 0;
  logic [1:0]  priv_i = 2'b11;
  logic        fready, ptr_o, tvalid, rvalid, rdisc;
  logic [1:0]  priv_o, outst;
  logic [31:0] taddr;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  cv32e40x_prefetcher_ot dut (
    .clk(clk), .rst_n(rst_n), .fetch_branch_i(br), .fetch_branch_addr_i(baddr),
    .fetch_valid_i(valid), .fetch_ready_o(fready), .fetch_ptr_access_i(ptr_i),
    .fetch_ptr_access_o(ptr_o), .fetch_priv_lvl_access_i(priv_i),
    .fetch_priv_lvl_access_o(priv_o), .trans_valid_o(tvalid), .trans_ready_i(ready),
    .trans_addr_o(taddr), .resp_valid_i(resp), .resp_valid_o(rvalid),
    .resp_discard_o(rdisc), .outstanding_o(outst)
  );
  typedef struct {
    logic br; logic [31:0] ba; logic v, rdy, rsp;
    logic fr, tv; logic [31:0] ta; logic rv, rd; logic [1:0] oc;
  } vec_t;
  vec_t tbl[28];
  function automatic vec_t mk(logic b, logic [31:0] ba, logic v, logic r, logic s,
                              logic fr, logic tv, logic [31:0] ta, logic rv, logic rd,
                              logic [1:0] oc);
    mk = '{b, ba, v, r, s, fr, tv, ta, rv, rd, oc};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //           br  baddr         v  r  s   fr tv taddr         rv rd oc
    tbl[0]  = mk(1, 32'h100,       1, 1, 0,  1, 1, 32'h100,       0, 0, 0);
    tbl[1]  = mk(0, 0,             1, 1, 1,  1, 1, 32'h104,       1, 0, 1);
    tbl[2]  = mk(0, 0,             1, 1, 1,  1, 1, 32'h108,       1, 0, 1);
    tbl[3]  = mk(0, 0,             1, 1, 0,  1, 1, 32'h10C,       0, 0, 1);
    tbl[4]  = mk(0, 0,             1, 1, 0,  0, 0, 32'h110,       0, 0, 2);
    tbl[5]  = mk(0, 0,             1, 1, 1,  0, 0, 32'h110,       1, 0, 2);
    tbl[6]  = mk(0, 0,             1, 0, 0,  0, 1, 32'h110,       0, 0, 1);
    tbl[7]  = mk(0, 0,             1, 1, 0,  1, 1, 32'h110,       0, 0, 1);
    tbl[8]  = mk(1, 32'h200,       1, 1, 0,  0, 0, 32'h200,       0, 0, 2);
    tbl[9]  = mk(0, 0,             1, 1, 1,  0, 0, 32'h200,       0, 1, 2);
    tbl[10] = mk(0, 0,             1, 1, 1,  1, 1, 32'h200,       0, 1, 1);
    tbl[11] = mk(0, 0,             0, 0, 1,  0, 0, 32'h204,       1, 0, 1);
    tbl[12] = mk(1, 32'h300,       1, 0, 0,  0, 1, 32'h300,       0, 0, 0);
    tbl[13] = mk(0, 0,             1, 0, 0,  0, 1, 32'h300,       0, 0, 0);
    tbl[14] = mk(0, 0,             1, 0, 0,  0, 1, 32'h300,       0, 0, 0);
    tbl[15] = mk(1, 32'h400,       1, 0, 0,  0, 1, 32'h400,       0, 0, 0);
    tbl[16] = mk(0, 0,             1, 1, 0,  1, 1, 32'h400,       0, 0, 0);
    tbl[17] = mk(0, 0,             1, 0, 0,  0, 1, 32'h404,       0, 0, 1);
    tbl[18] = mk(0, 0,             0, 0, 1,  0, 0, 32'h404,       1, 0, 1);
    tbl[19] = mk(1, 32'hFFFF_FFFC, 1, 1, 0,  1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    tbl[20] = mk(0, 0,             1, 1, 1,  1, 1, 32'h0,         1, 0, 1);
    tbl[21] = mk(0, 0,             0, 0, 1,  0, 0, 32'h4,         1, 0, 1);
    tbl[22] = mk(0, 0,             1, 1, 0,  1, 1, 32'h4,         0, 0, 0);
    tbl[23] = mk(0, 0,             1, 1, 0,  1, 1, 32'h8,         0, 0, 1);
    tbl[24] = mk(1, 32'h500,       1, 1, 0,  0, 0, 32'h500,       0, 0, 2);
    tbl[25] = mk(1, 32'h600,       1, 1, 1,  0, 0, 32'h600,       0, 1, 2);
    tbl[26] = mk(0, 0,             1, 1, 1,  1, 1, 32'h600,       0, 1, 1);
    tbl[27] = mk(0, 0,             0, 0, 1,  0, 0, 32'h604,       1, 0, 1);
    #2;
    chk("reset_outstanding", 32'(outst), 0);
    chk("reset_tvalid", 32'(tvalid), 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 28; i++) begin
      br = tbl[i].br; baddr = tbl[i].ba; valid = tbl[i].v; ready = tbl[i].rdy; resp = tbl[i].rsp;
      #3;
      chk($sformatf("v%0d_fetch_ready", i), 32'(fready), 32'(tbl[i].fr));
      chk($sformatf("v%0d_trans_valid", i), 32'(tvalid), 32'(tbl[i].tv));
      chk($sformatf("v%0d_trans_addr", i), taddr, tbl[i].ta);
      chk($sformatf("v%0d_resp_valid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_resp_discard", i), 32'(rdisc), 32'(tbl[i].rd));
      chk($sformatf("v%0d_outstanding", i), 32'(outst), 32'(tbl[i].oc));
      if (i == 1 || i == 2) chk($sformatf("v%0d_ptr_seq", i), 32'(ptr_o), 0);
      tick();
    end
    br = 0; valid = 0; ready = 0; resp = 0;
    // Pointer/privilege of a branch are replayed while the branch waits for the bus.
    br = 1; baddr = 32'h700; ptr_i = 1; priv_i = 2'b00; valid = 1; ready = 0;
    #3;
    chk("ptr_branch", 32'(ptr_o), 1);
    chk("priv_branch", 32'(priv_o), 0);
    tick();
    br = 0; ptr_i = 0; priv_i = 2'b11;
    #3;
    chk("ptr_replay", 32'(ptr_o), 1);
    chk("priv_replay", 32'(priv_o), 0);
    chk("addr_replay", taddr, 32'h700);
    ready = 1;
    tick();
    #3;
    chk("ptr_seq", 32'(ptr_o), 0);
    chk("priv_seq", 32'(priv_o), 3);
    chk("addr_seq", taddr, 32'h704);
    tick();
    chk("full_after_ptr", 32'(outst), 2);
    // Full, then branch: two stale, one response consumes one of them.
    br = 1; baddr = 32'h800; ready = 0;
    tick();
    br = 0; valid = 0; resp = 1;
    #3;
    chk("pre_rst_discard", 32'(rdisc), 1);
    tick();
    resp = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_outstanding", 32'(outst), 0);
    tick();
    rst_n = 1;
    tick();
    valid = 1; ready = 1; priv_i = 2'b11;
    #3;
    chk("post_rst_addr", taddr, 32'h4);
    chk("post_rst_priv", 32'(priv_o), 3);
    chk("post_rst_ptr", 32'(ptr_o), 0);
    tick();
    valid = 0; ready = 0; resp = 1;
    #3;
    chk("post_rst_resp_valid", 32'(rvalid), 1);
    chk("post_rst_no_discard", 32'(rdisc), 0);
    tick();
    resp = 0;
    #3;
    chk("post_rst_drained", 32'(outst), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
